// File: rtl/wide_add_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// wide_add_pkg
//   Shared types and constants for the wide add/subtract sequencer.
//   WORD_W       : width of the shared adder datapath.
//   state_t      : sequencer control states.
//   OP_ADD/OP_SUB: encodings of the op_sub input.
// ----------------------------------------------------------------------------
package wide_add_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// ----------------------------------------------------------------------------
// wide_add_sequencer_if
//   Operand/result bus of the wide add/subtract sequencer.
//   Request : in_valid, in_ready, op_sub, cin, a, b
//   Response: out_valid, out_ready, result, cout, ovf, zero
//   master  : operand producer / result consumer side
//   slave   : sequencer side
// ----------------------------------------------------------------------------
interface wide_add_sequencer_if #(
    parameter int unsigned NWORDS = 4
);
    import wide_add_pkg::*;

    localparam int unsigned W = WORD_W * NWORDS;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, op_sub, cin, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op_sub, cin, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );

endinterface

// File: rtl/wide_add_sequencer_wholeoperation.sv
// ----------------------------------------------------------------------------
// wholeoperation
//   32-bit carry-select adder: sum = x + y + cin.
//   x, y      : in  32-bit addends
//   cin       : in  carry-in
//   sum       : out 32-bit sum
//   finalcout : out carry-out of bit 31
// ----------------------------------------------------------------------------
module wholeoperation (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        finalcout
);

    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    // Upper half is precomputed for both possible carries from the lower half.
    always_comb begin
        lo  = {1'b0, x[15:0]}  + {1'b0, y[15:0]}  + {16'b0, cin};
        hi0 = {1'b0, x[31:16]} + {1'b0, y[31:16]};
        hi1 = {1'b0, x[31:16]} + {1'b0, y[31:16]} + 17'd1;
    end

    assign sum       = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
    assign finalcout = lo[16] ? hi1[16] : hi0[16];

endmodule

// File: rtl/wide_add_sequencer.sv
// ----------------------------------------------------------------------------
// wide_add_sequencer
//   Multi-precision add/subtract, one 32-bit word per clock, LSW first,
//   through a single shared carry-select adder.
//   clk   : in  clock
//   rst_n : in  asynchronous active-low reset
//   bus   : slave side of wide_add_sequencer_if (operands, result, flags)
//   busy  : out high whenever an operation is in flight or awaiting accept
// ----------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int unsigned NWORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    wide_add_sequencer_if.slave        bus,
    output logic                       busy
);
    import wide_add_pkg::*;

    localparam int unsigned IDX_W = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef logic [NWORDS-1:0][WORD_W-1:0] wide_t;

    state_t           state_q, state_d;
    wide_t            a_q, a_d;
    wide_t            b_q, b_d;
    wide_t            res_q, res_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [WORD_W-1:0] add_x;
    logic [WORD_W-1:0] add_y;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;
    logic              done;
    logic              y_msb;

    // Subtraction is a + ~b + ~borrow, so only b and the carry are inverted.
    assign add_x = a_q[idx_q];
    assign add_y = b_q[idx_q] ^ {WORD_W{op_q}};

    wholeoperation u_add (
        .x         (add_x),
        .y         (add_y),
        .cin       (carry_q),
        .sum       (add_sum),
        .finalcout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op_sub;
                    carry_d = (bus.op_sub == OP_SUB) ? ~bus.cin : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done  = (state_q == DONE);
    assign y_msb = b_q[NWORDS-1][WORD_W-1] ^ op_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = done;
    assign busy          = (state_q != IDLE);
    assign bus.result    = res_q;
    // Flags are only meaningful once the whole result is in; they read 0 otherwise.
    assign bus.cout = done & (op_q ? ~carry_q : carry_q);
    assign bus.ovf  = done & (a_q[NWORDS-1][WORD_W-1] == y_msb)
                           & (res_q[NWORDS-1][WORD_W-1] != a_q[NWORDS-1][WORD_W-1]);
    assign bus.zero = done & (res_q == '0);

endmodule
